// File: rtl/lcd_write_sequencer_if.sv
// lcd_write_sequencer_if: CPU-side write port and LCD pin bundle for the write sequencer
interface lcd_write_sequencer_if;
    logic        wr_en;
    logic        wr_rs;
    logic [7:0]  wr_data;
    logic        full;
    logic        busy;
    logic        overflow;
    logic [10:0] lcd_pins;
    modport master (output wr_en, wr_rs, wr_data, input full, busy, overflow, lcd_pins);
    modport slave  (input wr_en, wr_rs, wr_data, output full, busy, overflow, lcd_pins);
endinterface

// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: queues {rs,byte} writes and drives HD44780 setup/E-pulse/hold/exec timing
module lcd_write_sequencer #(
    parameter int SETUP_CYC      = 2,
    parameter int PULSE_CYC      = 12,
    parameter int HOLD_CYC       = 2,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int FIFO_DEPTH     = 4
) (
    input logic                 clk,
    input logic                 rst,
    lcd_write_sequencer_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [16:0] SETUP_T = 17'(SETUP_CYC - 1);
    localparam logic [16:0] PULSE_T = 17'(PULSE_CYC - 1);
    localparam logic [16:0] HOLD_T  = 17'(HOLD_CYC - 1);
    localparam logic [16:0] CMD_T   = 17'(CMD_WAIT_CYC - 1);
    localparam logic [16:0] CLR_T   = 17'(CLEAR_WAIT_CYC - 1);
    localparam logic [AW:0] DEPTH   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

    state_t       state_q, state_d;
    logic [16:0]  timer_q, timer_d;
    logic [8:0]   hold_q, hold_d;
    logic [AW:0]  count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic         overflow_q, overflow_d;
    logic [8:0]   mem_q [2**AW];
    logic         full, push, pop, done, is_clr;

    // FIFO bookkeeping, timer countdown and the write-cycle state machine
    always_comb begin
        full       = count_q == DEPTH;
        push       = bus.wr_en && !full;
        pop        = state_q == IDLE && count_q != '0;
        done       = timer_q == '0;
        is_clr     = !hold_q[8] && hold_q[7:2] == '0 && hold_q[1:0] != '0;
        count_d    = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = overflow_q || (bus.wr_en && full);
        state_d    = state_q;
        timer_d    = done ? timer_q : timer_q - 1'b1;
        hold_d     = hold_q;
        case (state_q)
            IDLE: if (pop) begin
                state_d = SETUP;
                timer_d = SETUP_T;
                hold_d  = mem_q[rd_ptr_q];
            end
            SETUP: if (done) begin
                state_d = PULSE;
                timer_d = PULSE_T;
            end
            PULSE: if (done) begin
                state_d = HOLD;
                timer_d = HOLD_T;
            end
            HOLD: if (done) begin
                state_d = WAIT;
                timer_d = is_clr ? CLR_T : CMD_T;
            end
            WAIT: if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset flushes the queue and clears the pins
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            hold_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            hold_q     <= hold_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are don't-care until counted in
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.wr_rs, bus.wr_data};
    end

    assign bus.full     = full;
    assign bus.busy     = state_q != IDLE || count_q != '0;
    assign bus.overflow = overflow_q;
    assign bus.lcd_pins = {state_q == PULSE, 1'b0, hold_q};
endmodule
